muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Multi-cycle multiply/divide controller that owns the HI/LO register pair for the pipelined MIPS core.
- Accepts one operation per start pulse from the EX stage and sequences a fixed-latency run.
- Commits the result to HI/LO and drives a stall request that the hazard unit ORs into PC/IF-ID enable and ID-EX clear.
- MTHI/MTLO complete in one cycle. MFHI/MFLO read the hi/lo outputs directly.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (must be ≥1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (must be ≥1).

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- start  in  1  EX-stage instruction is a valid MD op this cycle.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op.
- opr_a  in  WIDTH  rs operand, already forwarded.
- opr_b  in  WIDTH  rt operand, already forwarded.
- md_use_d  in  1  ID-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
- busy  out  1  run in progress.
- stall_req  out  1  hold ID, bubble EX.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset: state=IDLE, count=0, busy=0, hi=0, lo=0, pending result cleared. Reset during RUN aborts; the result is never committed.
- States:
  - IDLE: start with op 0xx → load pend_hi/pend_lo from the arithmetic sub-module and count=MULT_CYCLES (op 00x) or DIV_CYCLES (op 01x) → RUN.
  - IDLE: start with op 100 writes hi=opr_a at that edge; op 101 writes lo=opr_a. State stays IDLE, busy stays 0.
  - IDLE: start with op 11x is ignored.
  - RUN: count decrements each edge. On the edge where count==1: hi<=pend_hi, lo<=pend_lo, busy<=0 → IDLE.
- Latency: start sampled at edge E0 → busy=1 for exactly N cycles (E0..E0+N). New hi/lo are visible in the same cycle busy falls.
- Operands are latched at start; later changes to opr_a/opr_b have no effect.
- busy is a registered output: (state==RUN).
- stall_req = md_use_d & (busy | (start & ~op[2])). This is combinational, so the ID-stage consumer also stalls in the start cycle.
- start while busy is illegal because the hazard unit guarantees it never occurs. The design ignores it, and the bench asserts on it.
- Arithmetic (full 2*WIDTH product/quotient):
  - MULT: signed product, {hi,lo}=a*b.
  - MULTU: unsigned product.
  - DIV: lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - DIVU: unsigned quotient/remainder.
  - Signed 0x80000000 / -1: lo=0x80000000, hi=0.
- Divide by zero (DIV/DIVU, b==0): full DIV_CYCLES run, busy asserted normally, hi/lo left unchanged at commit.
- MTHI/MTLO while busy cannot occur because it is stalled. If it does occur, it is ignored.

Decomposition:
- Shared package muldiv_pkg:
  - op encodings MD_MULT..MD_MTLO.
  - state enum {MD_IDLE, MD_RUN}.
  - default cycle constants.
- One sub-module, muldiv_arith: purely combinational. Inputs are op, a, b. Outputs are res_hi, res_lo, and div_zero.
- muldiv_sequencer holds the FSM, counter, pending registers, HI/LO, and stall logic.

Test Plan:
- Reset, then MULT a=0xFFFFFFFD (-3), b=5:
  - busy high exactly 5 cycles, stall_req=0 while md_use_d=0.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFF1 as busy falls.
- MULTU a=0xFFFFFFFF, b=2 → hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7), b=2 → after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=7, b=2 → lo=3, hi=1.
- Signed 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles:
  - hi/lo update one edge after each start; busy never asserts.
  - Then DIVU b=0 → busy 10 cycles, hi/lo retain 0x12345678 / 0x9ABCDEF0.
- Stall and reset:
  - MULT start with md_use_d=1 → stall_req=1 in the start cycle and all 5 busy cycles, 0 afterward.
  - Assert reset at busy cycle 3 → next cycle busy=0, hi=lo=0, no later commit.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings, FSM states and default latencies for the HI/LO multiply/divide unit.
package muldiv_pkg;

    localparam logic [2:0] MD_MULT  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;
    localparam logic [2:0] MD_MTHI  = 3'b100;
    localparam logic [2:0] MD_MTLO  = 3'b101;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        MD_IDLE,
        MD_RUN
    } md_state_t;

endpackage

// File: rtl/muldiv_arith.sv
// Combinational full-width multiply and divide for MULT/MULTU/DIV/DIVU.
module muldiv_arith #(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             div_zero
);

    logic               w_signed;
    logic [2*WIDTH-1:0] w_a_ext;
    logic [2*WIDTH-1:0] w_b_ext;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_abs;
    logic [WIDTH-1:0]   w_b_abs;
    logic [WIDTH-1:0]   w_b_div;
    logic [WIDTH-1:0]   w_q_mag;
    logic [WIDTH-1:0]   w_r_mag;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;

    assign w_signed = ~op[0];

    // Truncated product of extended operands is the exact signed or unsigned 2*WIDTH product
    assign w_a_ext = {{WIDTH{w_signed & a[WIDTH-1]}}, a};
    assign w_b_ext = {{WIDTH{w_signed & b[WIDTH-1]}}, b};
    assign w_prod  = w_a_ext * w_b_ext;

    // Sign-magnitude divide: avoids the MIN/-1 overflow case and gives remainder the dividend's sign
    assign w_a_neg = w_signed & a[WIDTH-1];
    assign w_b_neg = w_signed & b[WIDTH-1];
    assign w_a_abs = w_a_neg ? -a : a;
    assign w_b_abs = w_b_neg ? -b : b;
    assign w_b_div = (b == '0) ? WIDTH'(1) : w_b_abs;
    assign w_q_mag = w_a_abs / w_b_div;
    assign w_r_mag = w_a_abs % w_b_div;
    assign w_quot  = (w_a_neg ^ w_b_neg) ? -w_q_mag : w_q_mag;
    assign w_rem   = w_a_neg ? -w_r_mag : w_r_mag;

    always_comb begin
        res_hi   = '0;
        res_lo   = '0;
        div_zero = 1'b0;
        case (op[2:1])
            2'b00: {res_hi, res_lo} = w_prod;
            2'b01: begin
                res_hi   = w_rem;
                res_lo   = w_quot;
                div_zero = (b == '0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Fixed-latency multiply/divide sequencer owning HI/LO, with stall request for the hazard unit.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] opr_a,
    input  logic [WIDTH-1:0] opr_b,
    input  logic             md_use_d,
    output logic             busy,
    output logic             stall_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    md_state_t        r_state;
    logic [CW-1:0]    r_count;
    logic             r_busy;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_pend_hi;
    logic [WIDTH-1:0] r_pend_lo;
    logic             r_pend_dz;

    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;
    logic             w_div_zero;

    muldiv_arith #(
        .WIDTH (WIDTH)
    ) u_arith (
        .op       (op),
        .a        (opr_a),
        .b        (opr_b),
        .res_hi   (w_res_hi),
        .res_lo   (w_res_lo),
        .div_zero (w_div_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= MD_IDLE;
            r_count   <= '0;
            r_busy    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_pend_dz <= 1'b0;
        end else begin
            case (r_state)
                MD_IDLE: begin
                    if (start) begin
                        if (!op[2]) begin
                            r_pend_hi <= w_res_hi;
                            r_pend_lo <= w_res_lo;
                            r_pend_dz <= w_div_zero;
                            r_count   <= op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                            r_busy    <= 1'b1;
                            r_state   <= MD_RUN;
                        end else if (op == MD_MTHI) begin
                            r_hi <= opr_a;
                        end else if (op == MD_MTLO) begin
                            r_lo <= opr_a;
                        end
                    end
                end
                MD_RUN: begin
                    // start/MTHI/MTLO here cannot occur under the hazard unit and are ignored
                    r_count <= r_count - CW'(1);
                    if (r_count == CW'(1)) begin
                        if (!r_pend_dz) begin
                            r_hi <= r_pend_hi;
                            r_lo <= r_pend_lo;
                        end
                        r_busy  <= 1'b0;
                        r_state <= MD_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign hi        = r_hi;
    assign lo        = r_lo;
    assign stall_req = md_use_d & (r_busy | (start & ~op[2]));

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer: latency, arithmetic, MTHI/MTLO, stall and reset abort.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] opr_a;
    logic [31:0] opr_b;
    logic        md_use_d;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    muldiv_sequencer #(
        .WIDTH       (32),
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .opr_a     (opr_a),
        .opr_b     (opr_b),
        .md_use_d  (md_use_d),
        .busy      (busy),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    // The hazard unit never issues an MD op while a run is in progress
    always @(posedge clk) begin
        if (!reset)
            assert (!(start && busy)) else $error("start asserted while busy");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one MULT/DIV op, count busy cycles, then check commit values as busy falls
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic md, input int unsigned exp_cycles,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        int unsigned n;
        old_hi   = hi;
        old_lo   = lo;
        start    = 1'b1;
        op       = o;
        opr_a    = a;
        opr_b    = b;
        md_use_d = md;
        #1;
        check_eq({tag, "_stall_start"}, 64'(stall_req), 64'(md));
        tick();
        start = 1'b0;
        opr_a = $urandom;
        opr_b = $urandom;
        n = 0;
        while (busy && n < 100) begin
            check_eq({tag, "_stall_busy"}, 64'(stall_req), 64'(md));
            check_eq({tag, "_hold"}, {hi, lo}, {old_hi, old_lo});
            n++;
            tick();
        end
        check_eq({tag, "_cycles"}, 64'(n), 64'(exp_cycles));
        check_eq({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        check_eq({tag, "_lo"}, 64'(lo), 64'(exp_lo));
        check_eq({tag, "_stall_after"}, 64'(stall_req), 64'd0);
        md_use_d = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        op       = 3'b111;
        opr_a    = '0;
        opr_b    = '0;
        md_use_d = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_hi", 64'(hi), 64'd0);
        check_eq("rst_lo", 64'(lo), 64'd0);
        check_eq("rst_stall", 64'(stall_req), 64'd0);

        run_op("mult",  3'b000, 32'hFFFFFFFD, 32'd5, 1'b0, 5, 32'hFFFFFFFF, 32'hFFFFFFF1);
        run_op("multu", 3'b001, 32'hFFFFFFFF, 32'd2, 1'b0, 5, 32'h00000001, 32'hFFFFFFFE);
        run_op("div",   3'b010, 32'hFFFFFFF9, 32'd2, 1'b0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu",  3'b011, 32'd7, 32'd2, 1'b0, 10, 32'h00000001, 32'h00000003);
        run_op("divov", 3'b010, 32'h80000000, 32'hFFFFFFFF, 1'b0, 10, 32'h00000000, 32'h80000000);

        // MTHI then MTLO on back-to-back cycles
        start = 1'b1;
        op    = 3'b100;
        opr_a = 32'h12345678;
        tick();
        check_eq("mthi_hi", 64'(hi), 64'h12345678);
        check_eq("mthi_busy", 64'(busy), 64'd0);
        op    = 3'b101;
        opr_a = 32'h9ABCDEF0;
        tick();
        start = 1'b0;
        check_eq("mtlo_lo", 64'(lo), 64'h9ABCDEF0);
        check_eq("mtlo_hi", 64'(hi), 64'h12345678);
        check_eq("mtlo_busy", 64'(busy), 64'd0);

        // No-op encoding: ignored, never stalls
        start    = 1'b1;
        op       = 3'b110;
        opr_a    = 32'hDEADBEEF;
        md_use_d = 1'b1;
        #1;
        check_eq("nop_stall", 64'(stall_req), 64'd0);
        tick();
        start    = 1'b0;
        md_use_d = 1'b0;
        check_eq("nop_busy", 64'(busy), 64'd0);
        check_eq("nop_hilo", {hi, lo}, 64'h12345678_9ABCDEF0);

        run_op("divz",  3'b011, 32'd99, 32'd0, 1'b0, 10, 32'h12345678, 32'h9ABCDEF0);
        run_op("stall", 3'b000, 32'd6, 32'd7, 1'b1, 5, 32'h00000000, 32'd42);

        // Reset during the third busy cycle aborts the run
        start    = 1'b1;
        op       = 3'b000;
        opr_a    = 32'd3;
        opr_b    = 32'd3;
        md_use_d = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check_eq("abort_busy3", 64'(busy), 64'd1);
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        md_use_d = 1'b0;
        check_eq("abort_busy", 64'(busy), 64'd0);
        check_eq("abort_hilo", {hi, lo}, 64'd0);
        for (int i = 0; i < 8; i++) tick();
        check_eq("abort_nocommit", {hi, lo}, 64'd0);
        check_eq("abort_idle", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
